// File: rtl/mem_stage_lsu.sv
`default_nettype none
// ============================================================================
// Module   : mem_stage_lsu
// Brief    : MEM-stage load/store unit with dmem handshake, pipeline stall,
//            byte-lane store alignment and sign/zero-extended load return.
// Revision : 1.0 - initial release
// ============================================================================
module mem_stage_lsu #(
  parameter int WAIT_LIMIT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_i,
  input  logic [6:0]  opcode_i,
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  store_type_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] rs2_i,
  output logic        stall_o,
  output logic [31:0] ld_data_o,
  output logic        ld_valid_o,
  output logic        misaligned_o,
  output logic        bus_error_o,
  output logic        dmem_read,
  output logic        dmem_write,
  output logic [31:0] dmem_address,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_byte_enable,
  input  logic        dmem_resp,
  input  logic [31:0] dmem_rdata
);

  localparam logic [6:0] C_OP_LOAD  = 7'b0000011;
  localparam logic [6:0] C_OP_STORE = 7'b0100011;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  localparam int            CW      = (WAIT_LIMIT < 1) ? 1 : $clog2(WAIT_LIMIT + 1);
  localparam logic [CW-1:0] C_LIMIT = CW'(WAIT_LIMIT);
  localparam logic [CW-1:0] C_ONE   = CW'(1);

  logic [1:0]    r_state, w_state_nxt;
  logic          w_is_load, w_is_store, w_mem_op, w_misalign, w_start, w_abort;
  logic [1:0]    w_size;
  logic [3:0]    w_be;
  logic [31:0]   w_wdata, w_ld_ext;
  logic [7:0]    w_byte;
  logic [15:0]   w_half;

  logic          r_is_store, r_load_ok, r_misaligned, r_bus_error;
  logic [2:0]    r_funct3;
  logic [1:0]    r_off;
  logic [CW-1:0] r_wait;
  logic [31:0]   r_addr, r_wdata, r_ld_data;
  logic [3:0]    r_be;

  assign w_is_load  = opcode_i == C_OP_LOAD;
  assign w_is_store = opcode_i == C_OP_STORE;
  assign w_mem_op   = valid_i & (w_is_load | w_is_store);

  // Access size: 0 byte, 1 half, 2 word; undefined load widths fall back to word.
  always_comb begin
    w_size = 2'd2;
    if (w_is_store) begin
      case (store_type_i)
        2'b01:   w_size = 2'd1;
        2'b10:   w_size = 2'd0;
        default: w_size = 2'd2;
      endcase
    end else begin
      case (funct3_i[1:0])
        2'b00:   w_size = 2'd0;
        2'b01:   w_size = 2'd1;
        default: w_size = 2'd2;
      endcase
    end
  end

  always_comb begin
    w_misalign = 1'b0;
    if (w_size == 2'd2)      w_misalign = addr_i[1:0] != 2'b00;
    else if (w_size == 2'd1) w_misalign = addr_i[0];
    w_be = 4'b1111;
    if (w_is_store && w_size == 2'd0)      w_be = 4'b0001 << addr_i[1:0];
    else if (w_is_store && w_size == 2'd1) w_be = 4'b0011 << addr_i[1:0];
  end

  assign w_wdata = rs2_i << {addr_i[1:0], 3'b000};
  assign w_start = (r_state == S_IDLE) & w_mem_op & ~w_misalign;
  assign w_abort = (WAIT_LIMIT != 0) && (r_wait == C_LIMIT) && !dmem_resp;

  always_comb begin
    w_byte = dmem_rdata[{r_off, 3'b000} +: 8];
    w_half = dmem_rdata[{r_off[1], 4'b0000} +: 16];
    case (r_funct3)
      3'b000:  w_ld_ext = {{24{w_byte[7]}}, w_byte};
      3'b001:  w_ld_ext = {{16{w_half[15]}}, w_half};
      3'b100:  w_ld_ext = {24'd0, w_byte};
      3'b101:  w_ld_ext = {16'd0, w_half};
      default: w_ld_ext = dmem_rdata;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (w_start) w_state_nxt = S_ACCESS;
      S_ACCESS: if (dmem_resp || w_abort) w_state_nxt = S_DONE;
      S_DONE:   w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    stall_o    = w_start | (r_state == S_ACCESS);
    dmem_read  = (r_state == S_ACCESS) & ~r_is_store;
    dmem_write = (r_state == S_ACCESS) & r_is_store;
    ld_valid_o = (r_state == S_DONE) & r_load_ok;
  end

  // Request snapshot is frozen for the whole access; r_wait counts ACCESS cycles including the current one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_is_store   <= 1'b0;
      r_load_ok    <= 1'b0;
      r_misaligned <= 1'b0;
      r_bus_error  <= 1'b0;
      r_funct3     <= 3'd0;
      r_off        <= 2'd0;
      r_wait       <= '0;
      r_addr       <= 32'd0;
      r_wdata      <= 32'd0;
      r_be         <= 4'd0;
      r_ld_data    <= 32'd0;
    end else begin
      r_misaligned <= (r_state == S_IDLE) & w_mem_op & w_misalign;
      r_bus_error  <= (r_state == S_ACCESS) & w_abort;
      if (w_start) begin
        r_addr     <= {addr_i[31:2], 2'b00};
        r_off      <= addr_i[1:0];
        r_be       <= w_be;
        r_wdata    <= w_wdata;
        r_funct3   <= funct3_i;
        r_is_store <= w_is_store;
        r_wait     <= C_ONE;
        r_load_ok  <= 1'b0;
      end else if (r_state == S_ACCESS) begin
        if (dmem_resp) begin
          r_load_ok <= ~r_is_store;
          if (!r_is_store) r_ld_data <= w_ld_ext;
        end else if ((WAIT_LIMIT != 0) && (r_wait != C_LIMIT)) begin
          r_wait <= r_wait + C_ONE;
        end
      end
    end
  end

  assign ld_data_o        = r_ld_data;
  assign misaligned_o     = r_misaligned;
  assign bus_error_o      = r_bus_error;
  assign dmem_address     = r_addr;
  assign dmem_wdata       = r_wdata;
  assign dmem_byte_enable = r_be;

endmodule
`default_nettype wire
